// File: rtl/dir_link_tx.sv
// dir_link_tx: frames the local player direction on each game tick
// and hands the bytes to a valid/ready byte transmitter.
package dir_link_pkg;
    typedef enum logic {
        MENU = 1'b0,
        GAME = 1'b1
    } game_mode;

    typedef enum logic [2:0] {
        NONE  = 3'b000,
        UP    = 3'b001,
        DOWN  = 3'b010,
        RIGHT = 3'b011,
        LEFT  = 3'b100
    } direction;
endpackage

module dir_link_tx
    import dir_link_pkg::*;
#(
    parameter bit SEND_NONE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_div,
    input  game_mode   mode,
    input  direction   dir1,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       sent,
    output logic       overrun
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0] state_q, state_d;
    logic       sync0_q, sync1_q, hist_q;
    game_mode   mode_q;
    logic [7:0] data_q, data_d;
    logic [1:0] seq_q, seq_d;
    logic       pend_v_q, pend_v_d;
    logic [2:0] pend_dir_q, pend_dir_d;
    logic       start_q, start_d;
    logic       sent_q, sent_d;
    logic       over_q, over_d;
    logic       tick, m2g, g2m, tick_ok, hs, direct;

    // marker, seq, dir, start flag, then even parity over the byte
    function automatic logic [7:0] frame(
        input logic [1:0] s,
        input logic [2:0] d,
        input logic       st
    );
        logic [6:0] f;
        f = {1'b1, s, d, st};
        return {f, ^f};
    endfunction

    assign tick    = sync1_q & ~hist_q;
    assign m2g     = (mode == GAME) && (mode_q == MENU);
    assign g2m     = (mode == MENU) && (mode_q == GAME);
    assign tick_ok = tick && (mode == GAME) && !m2g
                     && (SEND_NONE || (dir1 != NONE));
    assign hs      = (state_q == S_SEND) && tx_ready;

    // synchronize the game tick and remember the previous mode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            hist_q  <= 1'b0;
            mode_q  <= MENU;
        end else begin
            sync0_q <= clk_div;
            sync1_q <= sync0_q;
            hist_q  <= sync1_q;
            mode_q  <= mode;
        end
    end

    // frame sourcing, handshake, pending slot and seq bookkeeping
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        seq_d      = seq_q;
        pend_v_d   = pend_v_q;
        pend_dir_d = pend_dir_q;
        start_d    = start_q;
        sent_d     = 1'b0;
        over_d     = over_q;
        direct     = 1'b0;
        if (state_q == S_IDLE) begin
            if (m2g || start_q) begin
                data_d  = frame(2'd0, NONE, 1'b1);
                state_d = S_SEND;
                start_d = 1'b0;
            end else if (pend_v_q) begin
                data_d   = frame(seq_q, pend_dir_q, 1'b0);
                state_d  = S_SEND;
                pend_v_d = 1'b0;
            end else if (tick_ok) begin
                data_d  = frame(seq_q, dir1, 1'b0);
                state_d = S_SEND;
                direct  = 1'b1;
            end
        end else if (hs) begin
            state_d = S_IDLE;
            sent_d  = 1'b1;
            // a start frame always leaves seq at 1
            seq_d   = data_q[1] ? 2'd1 : seq_q + 2'd1;
        end
        if (m2g) begin
            seq_d    = 2'd0;
            pend_v_d = 1'b0;
            over_d   = 1'b0;
            // in SEND the start frame waits for the current handshake
            if (state_q == S_SEND) begin
                start_d = 1'b1;
            end
        end
        if (g2m) begin
            pend_v_d = 1'b0;
            start_d  = 1'b0;
        end
        if (tick_ok && !direct) begin
            if (pend_v_d) begin
                over_d = 1'b1;
            end
            pend_v_d   = 1'b1;
            pend_dir_d = dir1;
        end
    end

    // state registers; reset aborts SEND at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            data_q     <= 8'h00;
            seq_q      <= 2'd0;
            pend_v_q   <= 1'b0;
            pend_dir_q <= 3'b000;
            start_q    <= 1'b0;
            sent_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            seq_q      <= seq_d;
            pend_v_q   <= pend_v_d;
            pend_dir_q <= pend_dir_d;
            start_q    <= start_d;
            sent_q     <= sent_d;
            over_q     <= over_d;
        end
    end

    assign tx_data  = data_q;
    assign tx_valid = (state_q == S_SEND);
    assign sent     = sent_q;
    assign overrun  = over_q;
endmodule

// File: tb/tb_dir_link_tx.sv
// tb_dir_link_tx: directed vector table plus hand-written sequences
// for the direction frame transmitter.
module tb_dir_link_tx;
    import dir_link_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_div = 1'b0;
    logic       tx_ready = 1'b0;
    game_mode   mode = MENU;
    direction   dir1 = NONE;
    logic [7:0] a_data, b_data;
    logic       a_valid, b_valid, a_sent, b_sent, a_over, b_over;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       r;
        game_mode   m;
        logic       cd;
        direction   d;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       es;
        logic       eo;
    } vec_t;

    vec_t tbl[31];

    always #5 clk = ~clk;

    dir_link_tx u_a (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .mode(mode),
        .dir1(dir1), .tx_data(a_data), .tx_valid(a_valid),
        .tx_ready(tx_ready), .sent(a_sent), .overrun(a_over)
    );

    dir_link_tx #(.SEND_NONE(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .mode(mode),
        .dir1(dir1), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(tx_ready), .sent(b_sent), .overrun(b_over)
    );

    function automatic vec_t mk(
        input logic r, input game_mode m, input logic cd,
        input direction d, input logic rdy, input logic ev,
        input logic [7:0] ed, input logic es, input logic eo
    );
        vec_t v;
        v.r = r; v.m = m; v.cd = cd; v.d = d; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.es = es; v.eo = eo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // rise on clk_div, tick is taken on the edge of the third step
    task automatic tick_cycle(input direction d);
        dir1 = d;
        clk_div = 1'b1;
        step();
        step();
        clk_div = 1'b0;
        step();
    endtask

    initial begin
        tbl[0]  = mk(0, MENU, 0, NONE,  0, 0, 8'h00, 0, 0);
        tbl[1]  = mk(0, MENU, 0, NONE,  0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, MENU, 1, UP,    1, 0, 8'h00, 0, 0);
        tbl[3]  = mk(1, MENU, 1, UP,    1, 0, 8'h00, 0, 0);
        tbl[4]  = mk(1, MENU, 0, UP,    1, 0, 8'h00, 0, 0);
        tbl[5]  = mk(1, MENU, 1, UP,    1, 0, 8'h00, 0, 0);
        tbl[6]  = mk(1, MENU, 1, UP,    1, 0, 8'h00, 0, 0);
        tbl[7]  = mk(1, MENU, 0, UP,    1, 0, 8'h00, 0, 0);
        tbl[8]  = mk(1, GAME, 0, UP,    1, 1, 8'h82, 0, 0);
        tbl[9]  = mk(1, GAME, 0, UP,    1, 0, 8'h82, 1, 0);
        tbl[10] = mk(1, GAME, 0, UP,    1, 0, 8'h82, 0, 0);
        tbl[11] = mk(1, GAME, 1, UP,    1, 0, 8'h82, 0, 0);
        tbl[12] = mk(1, GAME, 1, UP,    1, 0, 8'h82, 0, 0);
        tbl[13] = mk(1, GAME, 0, UP,    1, 1, 8'hA5, 0, 0);
        tbl[14] = mk(1, GAME, 0, UP,    1, 0, 8'hA5, 1, 0);
        tbl[15] = mk(1, GAME, 0, LEFT,  0, 0, 8'hA5, 0, 0);
        tbl[16] = mk(1, GAME, 1, LEFT,  0, 0, 8'hA5, 0, 0);
        tbl[17] = mk(1, GAME, 0, LEFT,  0, 0, 8'hA5, 0, 0);
        tbl[18] = mk(1, GAME, 1, LEFT,  0, 1, 8'hD1, 0, 0);
        tbl[19] = mk(1, GAME, 0, RIGHT, 0, 1, 8'hD1, 0, 0);
        tbl[20] = mk(1, GAME, 1, RIGHT, 0, 1, 8'hD1, 0, 0);
        tbl[21] = mk(1, GAME, 0, RIGHT, 0, 1, 8'hD1, 0, 0);
        tbl[22] = mk(1, GAME, 0, RIGHT, 0, 1, 8'hD1, 0, 1);
        tbl[23] = mk(1, GAME, 0, RIGHT, 1, 0, 8'hD1, 1, 1);
        tbl[24] = mk(1, GAME, 0, RIGHT, 1, 1, 8'hED, 0, 1);
        tbl[25] = mk(1, GAME, 0, RIGHT, 1, 0, 8'hED, 1, 1);
        tbl[26] = mk(1, GAME, 0, RIGHT, 1, 0, 8'hED, 0, 1);
        tbl[27] = mk(1, GAME, 0, RIGHT, 1, 0, 8'hED, 0, 1);
        tbl[28] = mk(1, MENU, 0, RIGHT, 1, 0, 8'hED, 0, 1);
        tbl[29] = mk(1, GAME, 0, RIGHT, 1, 1, 8'h82, 0, 0);
        tbl[30] = mk(1, GAME, 0, RIGHT, 1, 0, 8'h82, 1, 0);

        for (int i = 0; i < 31; i++) begin
            rst_n    = tbl[i].r;
            mode     = tbl[i].m;
            clk_div  = tbl[i].cd;
            dir1     = tbl[i].d;
            tx_ready = tbl[i].rdy;
            step();
            chk($sformatf("row%0d valid", i), {7'd0, a_valid}, {7'd0, tbl[i].ev});
            chk($sformatf("row%0d data", i), a_data, tbl[i].ed);
            chk($sformatf("row%0d sent", i), {7'd0, a_sent}, {7'd0, tbl[i].es});
            chk($sformatf("row%0d overrun", i), {7'd0, a_over}, {7'd0, tbl[i].eo});
        end

        // NONE tick: sent by default instance, skipped when SEND_NONE=0
        tx_ready = 1'b1;
        tick_cycle(NONE);
        chk("none_a_valid", {7'd0, a_valid}, 8'd1);
        chk("none_a_data", a_data, 8'hA0);
        chk("none_b_valid", {7'd0, b_valid}, 8'd0);
        step();
        chk("none_a_sent", {7'd0, a_sent}, 8'd1);
        chk("none_b_sent", {7'd0, b_sent}, 8'd0);
        tick_cycle(UP);
        chk("up_a_data", a_data, 8'hC5);
        chk("up_b_valid", {7'd0, b_valid}, 8'd1);
        chk("up_b_data", b_data, 8'hA5);
        step();
        chk("up_b_sent", {7'd0, b_sent}, 8'd1);

        // reset while a frame is stalled
        tx_ready = 1'b0;
        tick_cycle(DOWN);
        chk("stall_valid", {7'd0, a_valid}, 8'd1);
        chk("stall_data", a_data, 8'hE8);
        rst_n = 1'b0;
        mode = MENU;
        #1;
        chk("rst_abort_valid", {7'd0, a_valid}, 8'd0);
        chk("rst_abort_data", a_data, 8'h00);
        chk("rst_abort_b_valid", {7'd0, b_valid}, 8'd0);
        step();
        step();
        rst_n = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_rst%0d valid", i), {7'd0, a_valid}, 8'd0);
        end
        tx_ready = 1'b0;
        mode = GAME;
        step();
        chk("restart_valid", {7'd0, a_valid}, 8'd1);
        chk("restart_data", a_data, 8'h82);

        // leave and re-enter GAME mid-frame, then tick behind the start
        mode = MENU;
        step();
        chk("g2m_hold_valid", {7'd0, a_valid}, 8'd1);
        chk("g2m_hold_data", a_data, 8'h82);
        mode = GAME;
        step();
        tick_cycle(UP);
        chk("queued_valid", {7'd0, a_valid}, 8'd1);
        tx_ready = 1'b1;
        step();
        chk("q_hs1_sent", {7'd0, a_sent}, 8'd1);
        chk("q_hs1_valid", {7'd0, a_valid}, 8'd0);
        step();
        chk("q_start_valid", {7'd0, a_valid}, 8'd1);
        chk("q_start_data", a_data, 8'h82);
        step();
        chk("q_hs2_sent", {7'd0, a_sent}, 8'd1);
        step();
        chk("q_tick_valid", {7'd0, a_valid}, 8'd1);
        chk("q_tick_data", a_data, 8'hA5);
        step();
        chk("q_hs3_sent", {7'd0, a_sent}, 8'd1);
        chk("q_overrun", {7'd0, a_over}, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
